// File: rtl/h_bdy_eng_disp_if.sv
// Bus bundle between the body front-end, the exe_GEN engines and the engine dispatcher.
// H_BDY_ENG_DISP_STATS_EN adds the statistics outputs to the bundle.
interface h_bdy_eng_disp_if #(
  parameter int ENGS_N = 4,
  parameter int CMD_W  = 32,
  parameter int TAG_W  = 6
);
  localparam int ENG_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

  logic              cmd_vld;
  logic [CMD_W-1:0]  cmd_dat;
  logic [TAG_W-1:0]  cmd_tag;
  logic              cmd_rdy;
  logic [ENGS_N-1:0] eng_vld;
  logic [CMD_W-1:0]  eng_dat;
  logic [ENGS_N-1:0] eng_done;
  logic              cpl_vld;
  logic [ENG_W-1:0]  cpl_eng;
  logic [TAG_W-1:0]  cpl_tag;
  logic              cpl_rdy;
  logic              err_spurious;
`ifdef H_BDY_ENG_DISP_STATS_EN
  logic [31:0]       stat_issue_cnt;
  logic [31:0]       stat_cpl_cnt;
  logic [ENG_W:0]    stat_inflight;
`endif

  // Master is the surrounding system; slave is the dispatcher itself.
  modport master (
    output cmd_vld, cmd_dat, cmd_tag, eng_done, cpl_rdy,
`ifdef H_BDY_ENG_DISP_STATS_EN
    input  stat_issue_cnt, stat_cpl_cnt, stat_inflight,
`endif
    input  cmd_rdy, eng_vld, eng_dat, cpl_vld, cpl_eng, cpl_tag, err_spurious
  );

  modport slave (
    input  cmd_vld, cmd_dat, cmd_tag, eng_done, cpl_rdy,
`ifdef H_BDY_ENG_DISP_STATS_EN
    output stat_issue_cnt, stat_cpl_cnt, stat_inflight,
`endif
    output cmd_rdy, eng_vld, eng_dat, cpl_vld, cpl_eng, cpl_tag, err_spurious
  );
endinterface

// File: rtl/h_bdy_eng_disp.sv
// Round-robin dispatcher for the body-engine array: issues tagged commands and returns completions.
// Optional statistics counters are enabled with H_BDY_ENG_DISP_STATS_EN.
module h_bdy_eng_disp #(
  parameter int ENGS_N = 4,
  parameter int CMD_W  = 32,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              arst_n,
  h_bdy_eng_disp_if.slave   bus
);
  localparam int ENG_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]        state_q [ENGS_N];
  logic [1:0]        state_d [ENGS_N];
  logic [TAG_W-1:0]  tag_q   [ENGS_N];
  logic [TAG_W-1:0]  tag_d   [ENGS_N];
  logic [ENG_W-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [ENG_W-1:0]  cpl_ptr_q, cpl_ptr_d;
  logic [ENGS_N-1:0] eng_vld_q, eng_vld_d;
  logic [CMD_W-1:0]  eng_dat_q, eng_dat_d;
  logic              err_q, err_d;

  logic [ENGS_N-1:0] idle_vec, done_vec;
  logic [ENG_W-1:0]  alloc_sel, cpl_sel;
  logic              accept, cpl_hs;

  // First requester at or after ptr, wrapping at ENGS_N-1.
  function automatic logic [ENG_W-1:0] rr_pick(input logic [ENGS_N-1:0] req,
                                               input logic [ENG_W-1:0]  ptr);
    logic [ENG_W-1:0] pick;
    logic [ENG_W:0]   idx;
    pick = '0;
    for (int i = ENGS_N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (ENG_W+1)'(i);
      if (idx >= (ENG_W+1)'(ENGS_N)) idx = idx - (ENG_W+1)'(ENGS_N);
      if (req[idx[ENG_W-1:0]]) pick = idx[ENG_W-1:0];
    end
    return pick;
  endfunction

  function automatic logic [ENG_W-1:0] rr_next(input logic [ENG_W-1:0] sel);
    return (sel == ENG_W'(ENGS_N - 1)) ? '0 : sel + ENG_W'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < ENGS_N; k++) begin
      idle_vec[k] = (state_q[k] == ST_IDLE);
      done_vec[k] = (state_q[k] == ST_DONE);
    end
  end

  assign alloc_sel        = rr_pick(idle_vec, alloc_ptr_q);
  assign cpl_sel          = rr_pick(done_vec, cpl_ptr_q);
  assign accept           = bus.cmd_vld & (|idle_vec);
  assign cpl_hs           = (|done_vec) & bus.cpl_rdy;

  assign bus.cmd_rdy      = |idle_vec;
  assign bus.cpl_vld      = |done_vec;
  assign bus.cpl_eng      = cpl_sel;
  assign bus.cpl_tag      = tag_q[cpl_sel];
  assign bus.eng_vld      = eng_vld_q;
  assign bus.eng_dat      = eng_dat_q;
  assign bus.err_spurious = err_q;

  // A retiring engine stays unallocatable this cycle because alloc_sel looks only at state_q.
  always_comb begin
    err_d       = err_q;
    alloc_ptr_d = accept ? rr_next(alloc_sel) : alloc_ptr_q;
    cpl_ptr_d   = cpl_hs ? rr_next(cpl_sel) : cpl_ptr_q;
    eng_vld_d   = '0;
    eng_dat_d   = eng_dat_q;
    if (accept) begin
      eng_vld_d[alloc_sel] = 1'b1;
      eng_dat_d            = bus.cmd_dat;
    end
    for (int k = 0; k < ENGS_N; k++) begin
      state_d[k] = state_q[k];
      tag_d[k]   = tag_q[k];
      case (state_q[k])
        ST_IDLE: if (accept && alloc_sel == ENG_W'(k)) begin
                   state_d[k] = ST_BUSY;
                   tag_d[k]   = bus.cmd_tag;
                 end
        ST_BUSY: if (bus.eng_done[k]) state_d[k] = ST_DONE;
        ST_DONE: if (cpl_hs && cpl_sel == ENG_W'(k)) state_d[k] = ST_IDLE;
        default: state_d[k] = ST_IDLE;
      endcase
      if (bus.eng_done[k] && state_q[k] != ST_BUSY) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < ENGS_N; k++) begin
        state_q[k] <= ST_IDLE;
        tag_q[k]   <= '0;
      end
      alloc_ptr_q <= '0;
      cpl_ptr_q   <= '0;
      eng_vld_q   <= '0;
      eng_dat_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int k = 0; k < ENGS_N; k++) begin
        state_q[k] <= state_d[k];
        tag_q[k]   <= tag_d[k];
      end
      alloc_ptr_q <= alloc_ptr_d;
      cpl_ptr_q   <= cpl_ptr_d;
      eng_vld_q   <= eng_vld_d;
      eng_dat_q   <= eng_dat_d;
      err_q       <= err_d;
    end
  end

`ifdef H_BDY_ENG_DISP_STATS_EN
  logic [31:0]    issue_cnt_q, issue_cnt_d;
  logic [31:0]    cpl_cnt_q, cpl_cnt_d;
  logic [ENG_W:0] inflight_q, inflight_d;

  // Inflight is counted from the next state so the register matches the engine states it sits beside.
  always_comb begin
    issue_cnt_d = (accept && issue_cnt_q != '1) ? issue_cnt_q + 32'd1 : issue_cnt_q;
    cpl_cnt_d   = (cpl_hs && cpl_cnt_q != '1) ? cpl_cnt_q + 32'd1 : cpl_cnt_q;
    inflight_d  = '0;
    for (int k = 0; k < ENGS_N; k++) begin
      if (state_d[k] != ST_IDLE) inflight_d = inflight_d + (ENG_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      issue_cnt_q <= '0;
      cpl_cnt_q   <= '0;
      inflight_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      cpl_cnt_q   <= cpl_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  assign bus.stat_issue_cnt = issue_cnt_q;
  assign bus.stat_cpl_cnt   = cpl_cnt_q;
  assign bus.stat_inflight  = inflight_q;
`endif
endmodule

// File: tb/tb_h_bdy_eng_disp.sv
// Self-checking bench for h_bdy_eng_disp: directed scenarios followed by randomized traffic,
// all compared against a slot-occupancy model of the engine array.
module tb_h_bdy_eng_disp;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  h_bdy_eng_disp_if #(.ENGS_N(N), .CMD_W(CW), .TAG_W(TW)) bus ();

  h_bdy_eng_disp #(.ENGS_N(N), .CMD_W(CW), .TAG_W(TW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which slots hold a command, which of those have finished, and their tags.
  bit          inUse    [N];
  bit          finished [N];
  int          tagOf    [N];
  int          allocPtr, cplPtr;
  logic [N-1:0]  expEngVld;
  logic [CW-1:0] expEngDat;
  bit          expErr;
  int          issues, cpls;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int firstFree();
    for (int i = 0; i < N; i++) if (!inUse[(allocPtr + i) % N]) return (allocPtr + i) % N;
    return -1;
  endfunction

  function automatic int firstFinished();
    for (int i = 0; i < N; i++) if (finished[(cplPtr + i) % N]) return (cplPtr + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] runningMask();
    logic [N-1:0] m;
    for (int k = 0; k < N; k++) m[k] = inUse[k] && !finished[k];
    return m;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < N; k++) begin
      inUse[k] = 0; finished[k] = 0; tagOf[k] = 0;
    end
    allocPtr = 0; cplPtr = 0; expEngVld = '0; expEngDat = '0; expErr = 0;
    issues = 0; cpls = 0;
  endtask

  // Drives one cycle of inputs, checks outputs mid-cycle and after the edge.
  task automatic applyStimulus(input bit vld, input logic [CW-1:0] dat, input logic [TW-1:0] tag,
                               input logic [N-1:0] done, input bit cplRdy);
    int sel, cidx, inflight;
    bit acc, hs;
    logic [N-1:0] running;
    bus.cmd_vld = vld; bus.cmd_dat = dat; bus.cmd_tag = tag;
    bus.eng_done = done; bus.cpl_rdy = cplRdy;
    #4;
    sel  = firstFree();
    cidx = firstFinished();
    checkOutput("cmd_rdy", 64'(bus.cmd_rdy), 64'(sel >= 0));
    checkOutput("cpl_vld", 64'(bus.cpl_vld), 64'(cidx >= 0));
    if (cidx >= 0) begin
      checkOutput("cpl_eng", 64'(bus.cpl_eng), 64'(cidx));
      checkOutput("cpl_tag", 64'(bus.cpl_tag), 64'(tagOf[cidx]));
    end
    acc = vld && (sel >= 0);
    hs  = cplRdy && (cidx >= 0);
    running = runningMask();
    for (int k = 0; k < N; k++) begin
      if (done[k]) begin
        if (running[k]) finished[k] = 1;
        else expErr = 1;
      end
    end
    if (hs) begin
      inUse[cidx] = 0; finished[cidx] = 0; cplPtr = (cidx + 1) % N; cpls++;
    end
    if (acc) begin
      inUse[sel] = 1; finished[sel] = 0; tagOf[sel] = int'(tag);
      allocPtr = (sel + 1) % N; issues++;
      expEngVld = N'(1) << sel; expEngDat = dat;
    end else begin
      expEngVld = '0;
    end
    @(posedge clk);
    #1;
    checkOutput("eng_vld", 64'(bus.eng_vld), 64'(expEngVld));
    if (expEngVld != '0) checkOutput("eng_dat", 64'(bus.eng_dat), 64'(expEngDat));
    checkOutput("err_spurious", 64'(bus.err_spurious), 64'(expErr));
`ifdef H_BDY_ENG_DISP_STATS_EN
    inflight = 0;
    for (int k = 0; k < N; k++) if (inUse[k]) inflight++;
    checkOutput("stat_issue_cnt", 64'(bus.stat_issue_cnt), 64'(issues));
    checkOutput("stat_cpl_cnt", 64'(bus.stat_cpl_cnt), 64'(cpls));
    checkOutput("stat_inflight", 64'(bus.stat_inflight), 64'(inflight));
`else
    inflight = 0;
`endif
  endtask

  task automatic idleCycle(input logic [N-1:0] done, input bit cplRdy);
    applyStimulus(1'b0, '0, '0, done, cplRdy);
  endtask

  // Asserts reset asynchronously, checks the cleared outputs, releases away from the edge.
  task automatic applyReset();
    arst_n = 1'b0;
    bus.cmd_vld = 1'b0; bus.cmd_dat = '0; bus.cmd_tag = '0; bus.eng_done = '0; bus.cpl_rdy = 1'b0;
    #3;
    modelReset();
    checkOutput("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
    checkOutput("rst_cpl_vld", 64'(bus.cpl_vld), 64'd0);
    checkOutput("rst_eng_vld", 64'(bus.eng_vld), 64'd0);
    checkOutput("rst_eng_dat", 64'(bus.eng_dat), 64'd0);
    checkOutput("rst_err", 64'(bus.err_spurious), 64'd0);
`ifdef H_BDY_ENG_DISP_STATS_EN
    checkOutput("rst_stat_issue", 64'(bus.stat_issue_cnt), 64'd0);
    checkOutput("rst_stat_cpl", 64'(bus.stat_cpl_cnt), 64'd0);
    checkOutput("rst_stat_inflight", 64'(bus.stat_inflight), 64'd0);
`endif
    @(posedge clk);
    #2;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] done;
    bit vld, rdy;
    applyReset();

    // Four back-to-back commands, tags 1..4, fill engines 0..3 in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, CW'($urandom), TW'(i + 1), '0, 1'b0);
      checkOutput("b2b_eng_vld", 64'(bus.eng_vld), 64'(4'b0001 << i));
    end
    checkOutput("full_cmd_rdy", 64'(bus.cmd_rdy), 64'd0);

    // Engines 2 and 0 finish together; completions come back as 0 then 2.
    idleCycle(4'b0101, 1'b1);
    checkOutput("dual_cpl_eng0", 64'(bus.cpl_eng), 64'd0);
    checkOutput("dual_cpl_tag1", 64'(bus.cpl_tag), 64'd1);
    idleCycle('0, 1'b1);
    checkOutput("dual_cpl_eng2", 64'(bus.cpl_eng), 64'd2);
    checkOutput("dual_cpl_tag3", 64'(bus.cpl_tag), 64'd3);
    checkOutput("retire_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
    idleCycle('0, 1'b1);

    // Engine 1 finishes and is held by back-pressure for five cycles.
    idleCycle(4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_cpl_vld", 64'(bus.cpl_vld), 64'd1);
      checkOutput("hold_cpl_eng", 64'(bus.cpl_eng), 64'd1);
      checkOutput("hold_cpl_tag", 64'(bus.cpl_tag), 64'd2);
      idleCycle('0, 1'b0);
    end
    idleCycle('0, 1'b1);

    // Refill to full, then a completion and a new command in the same cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, CW'($urandom), TW'(i + 5), '0, 1'b0);
    idleCycle(4'b0001, 1'b0);
    applyStimulus(1'b1, 32'hCAFE_0008, 6'd8, '0, 1'b1);
    checkOutput("nobypass_eng_vld", 64'(bus.eng_vld), 64'd0);
    applyStimulus(1'b1, 32'hCAFE_0008, 6'd8, '0, 1'b0);
    checkOutput("late_accept_eng_vld", 64'(bus.eng_vld), 64'(4'b0001));
    checkOutput("late_accept_eng_dat", 64'(bus.eng_dat), 64'h0000_0000_CAFE_0008);

    // Retire engine 3, then pulse its done while it is idle.
    idleCycle(4'b1000, 1'b1);
    idleCycle('0, 1'b1);
    checkOutput("pre_spur_err", 64'(bus.err_spurious), 64'd0);
    idleCycle(4'b1000, 1'b0);
    checkOutput("spur_err", 64'(bus.err_spurious), 64'd1);
    checkOutput("spur_cpl_vld", 64'(bus.cpl_vld), 64'd0);

    // Randomized traffic with occasional spurious done pulses.
    for (int i = 0; i < 400; i++) begin
      vld  = ($urandom_range(0, 9) < 6);
      rdy  = ($urandom_range(0, 9) < 7);
      done = N'($urandom) & runningMask();
      if ($urandom_range(0, 29) == 0) done = done | (N'(1) << $urandom_range(0, N - 1));
      applyStimulus(vld, CW'($urandom), TW'($urandom), done, rdy);
    end

    // Reset in the middle of traffic discards everything.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, CW'($urandom), TW'($urandom), '0, 1'b0);
    idleCycle(runningMask(), 1'b0);
    applyReset();
    idleCycle('0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      vld  = ($urandom_range(0, 9) < 5);
      done = N'($urandom) & runningMask();
      applyStimulus(vld, CW'($urandom), TW'($urandom), done, ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
